// File: rtl/vx_mem_sched.sv
// rtl/vx_mem_sched.sv - credit-limited round-robin scheduler sharing one memory port among NUM_REQS requesters.
// Optional perf counters are enabled with `define VX_MEM_SCHED_PERF_EN.
module vx_mem_sched #(
    parameter int NUM_REQS      = 4,
    parameter int DATA_WIDTH    = 512,
    parameter int ADDR_WIDTH    = 26,
    parameter int TAG_IN_WIDTH  = 8,
    parameter int MAX_PENDING   = 8,
    parameter int SEL_BITS      = $clog2(NUM_REQS),
    parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS,
    parameter int BYTEEN_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_REQS-1:0]                       req_valid_in,
    input  logic [NUM_REQS-1:0]                       req_rw_in,
    input  logic [NUM_REQS-1:0][BYTEEN_WIDTH-1:0]     req_byteen_in,
    input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]       req_addr_in,
    input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]       req_data_in,
    input  logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]     req_tag_in,
    output logic [NUM_REQS-1:0]                       req_ready_in,
    output logic                                      req_valid_out,
    output logic                                      req_rw_out,
    output logic [BYTEEN_WIDTH-1:0]                   req_byteen_out,
    output logic [ADDR_WIDTH-1:0]                     req_addr_out,
    output logic [DATA_WIDTH-1:0]                     req_data_out,
    output logic [TAG_OUT_WIDTH-1:0]                  req_tag_out,
    input  logic                                      req_ready_out,
    input  logic                                      rsp_valid_in,
    input  logic [DATA_WIDTH-1:0]                     rsp_data_in,
    input  logic [TAG_OUT_WIDTH-1:0]                  rsp_tag_in,
    output logic                                      rsp_ready_in,
    output logic [NUM_REQS-1:0]                       rsp_valid_out,
    output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]       rsp_data_out,
    output logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]     rsp_tag_out,
    input  logic [NUM_REQS-1:0]                       rsp_ready_out,
    output logic                                      busy
`ifdef VX_MEM_SCHED_PERF_EN
    ,
    output logic [63:0]                               perf_stall_cycles,
    output logic [63:0]                               perf_reads
`endif
);

    localparam int SEL_W = (SEL_BITS > 0) ? SEL_BITS : 1;
    localparam int PW    = $clog2(MAX_PENDING + 1);

    logic [SEL_W-1:0]              rr;
    logic [SEL_W-1:0]              grant_idx;
    logic                          grant_any;
    logic [NUM_REQS-1:0]           grant;
    logic [NUM_REQS-1:0]           eligible;
    logic [NUM_REQS-1:0]           rd_acc;
    logic [NUM_REQS-1:0]           rsp_fire;
    logic [NUM_REQS-1:0][PW-1:0]   pend;
    logic [TAG_OUT_WIDTH-1:0]      tag_next;
    logic [SEL_W-1:0]              rsp_route;
    logic                          rsp_pending;
    logic [SEL_W-1:0]              rsp_idx;
    logic [DATA_WIDTH-1:0]         rsp_data_reg;
    logic [TAG_IN_WIDTH-1:0]       rsp_tag_reg;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = req_valid_in[i] && (req_rw_in[i] || (pend[i] < PW'(MAX_PENDING)));
        end
    end

    // First eligible requester at or after rr wins; nothing is granted while the request register is full.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (!reset && (!req_valid_out || req_ready_out)) begin
            for (int k = 0; k < NUM_REQS; k++) begin
                idx = (int'(rr) + k) % NUM_REQS;
                if (!grant_any && eligible[idx]) begin
                    grant_any  = 1'b1;
                    grant_idx  = SEL_W'(idx);
                    grant[idx] = 1'b1;
                end
            end
        end
    end

    assign req_ready_in = grant;
    assign rd_acc       = grant & ~req_rw_in;

    generate
        if (SEL_BITS > 0) begin : g_idx
            assign tag_next  = {grant_idx, req_tag_in[grant_idx]};
            assign rsp_route = rsp_tag_in[TAG_OUT_WIDTH-1 -: SEL_BITS];
        end else begin : g_noidx
            assign tag_next  = req_tag_in[0];
            assign rsp_route = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            rr            <= '0;
            req_valid_out <= 1'b0;
        end else if (grant_any) begin
            rr             <= (grant_idx == SEL_W'(NUM_REQS - 1)) ? '0 : grant_idx + SEL_W'(1);
            req_valid_out  <= 1'b1;
            req_rw_out     <= req_rw_in[grant_idx];
            req_byteen_out <= req_byteen_in[grant_idx];
            req_addr_out   <= req_addr_in[grant_idx];
            req_data_out   <= req_data_in[grant_idx];
            req_tag_out    <= tag_next;
        end else if (req_ready_out) begin
            req_valid_out <= 1'b0;
        end
    end

    assign rsp_ready_in = !rsp_pending || rsp_ready_out[rsp_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_pending <= 1'b0;
            rsp_idx     <= '0;
        end else if (rsp_valid_in && rsp_ready_in) begin
            rsp_pending  <= 1'b1;
            rsp_idx      <= rsp_route;
            rsp_data_reg <= rsp_data_in;
            rsp_tag_reg  <= rsp_tag_in[TAG_IN_WIDTH-1:0];
        end else if (rsp_ready_out[rsp_idx]) begin
            rsp_pending <= 1'b0;
        end
    end

    generate
        for (genvar i = 0; i < NUM_REQS; i++) begin : g_rsp
            assign rsp_valid_out[i] = rsp_pending && (rsp_idx == SEL_W'(i));
            assign rsp_data_out[i]  = rsp_data_reg;
            assign rsp_tag_out[i]   = rsp_tag_reg;
            assign rsp_fire[i]      = rsp_valid_out[i] && rsp_ready_out[i];
        end
    endgenerate

    // A read issued and a response delivered in the same cycle cancel out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQS; i++) begin
            if (reset) begin
                pend[i] <= '0;
            end else if (rd_acc[i] && !rsp_fire[i]) begin
                pend[i] <= pend[i] + PW'(1);
            end else if (rsp_fire[i] && !rd_acc[i] && (pend[i] != '0)) begin
                pend[i] <= pend[i] - PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                credit_underflow: assert (!(rsp_fire[i] && (pend[i] == '0)));
            end
        end
    end

    assign busy = (|pend) || req_valid_out || rsp_pending;

`ifdef VX_MEM_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_reads        <= '0;
        end else begin
            if ((|req_valid_in) && !grant_any) perf_stall_cycles <= perf_stall_cycles + 64'd1;
            if (|rd_acc) perf_reads <= perf_reads + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vx_mem_sched.sv
// tb/tb_vx_mem_sched.sv - directed self-checking bench for vx_mem_sched.
module tb_vx_mem_sched;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int AW  = 26;
    localparam int TW  = 8;
    localparam int TOW = 10;
    localparam int BW  = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NR-1:0]           req_valid_in, req_rw_in, req_ready_in;
    logic [NR-1:0][BW-1:0]   req_byteen_in;
    logic [NR-1:0][AW-1:0]   req_addr_in;
    logic [NR-1:0][DW-1:0]   req_data_in;
    logic [NR-1:0][TW-1:0]   req_tag_in;
    logic                    req_valid_out, req_rw_out, req_ready_out;
    logic [BW-1:0]           req_byteen_out;
    logic [AW-1:0]           req_addr_out;
    logic [DW-1:0]           req_data_out;
    logic [TOW-1:0]          req_tag_out;
    logic                    rsp_valid_in, rsp_ready_in;
    logic [DW-1:0]           rsp_data_in;
    logic [TOW-1:0]          rsp_tag_in;
    logic [NR-1:0]           rsp_valid_out, rsp_ready_out;
    logic [NR-1:0][DW-1:0]   rsp_data_out;
    logic [NR-1:0][TW-1:0]   rsp_tag_out;
    logic                    busy;
`ifdef VX_MEM_SCHED_PERF_EN
    logic [63:0]             perf_stall_cycles, perf_reads;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    vx_mem_sched #(
        .NUM_REQS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW), .MAX_PENDING(2)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_byteen_in(req_byteen_in),
        .req_addr_in(req_addr_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .req_ready_in(req_ready_in),
        .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_byteen_out(req_byteen_out),
        .req_addr_out(req_addr_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
        .req_ready_out(req_ready_out),
        .rsp_valid_in(rsp_valid_in), .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in),
        .rsp_ready_in(rsp_ready_in),
        .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out),
        .rsp_ready_out(rsp_ready_out),
        .busy(busy)
`ifdef VX_MEM_SCHED_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_reads(perf_reads)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        req_valid_in  = '0;
        req_rw_in     = '0;
        req_ready_out = 1'b1;
        rsp_valid_in  = 1'b0;
        rsp_data_in   = '0;
        rsp_tag_in    = '0;
        rsp_ready_out = 4'hF;
        for (int i = 0; i < NR; i++) begin
            req_byteen_in[i] = 4'hF;
            req_addr_in[i]   = AW'(26'h100 + i);
            req_data_in[i]   = 32'hD000_0000 + i;
            req_tag_in[i]    = TW'(8'h10 + i);
        end
        req_addr_in[1] = 26'h111;
        step();
        step();
        check("rst_req_valid_out", req_valid_out, 0);
        check("rst_rsp_valid_out", rsp_valid_out, 0);
        check("rst_busy", busy, 0);
        check("rst_rr", dut.rr, 0);
        reset = 1'b0;
        #1;
        check("rst_rsp_ready_in", rsp_ready_in, 1);

        // fairness: continuous writes from all requesters
        req_valid_in = 4'hF;
        req_rw_in    = 4'hF;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("fair_grant", req_ready_in, 64'(1 << (k % 4)));
            step();
            check("fair_valid", req_valid_out, 1);
            check("fair_tag", req_tag_out, 64'(((k % 4) << 8) | (8'h10 + k % 4)));
            check("fair_data", req_data_out, 64'(32'hD000_0000 + k % 4));
        end
        check("fair_rr", dut.rr, 2);
        check("fair_pend", dut.pend, 0);

        // credit limit on requester 1
        req_valid_in = 4'b0010;
        req_rw_in    = 4'b0000;
        #1; check("cred_rd1", req_ready_in, 4'b0010);
        step();
        #1; check("cred_rd2", req_ready_in, 4'b0010);
        step();
        #1; check("cred_stall", req_ready_in, 0);
        check("cred_pend2", dut.pend[1], 2);
        rsp_valid_in = 1'b1;
        rsp_tag_in   = {2'd1, 8'h33};
        rsp_data_in  = 32'hCAFE_0001;
        #1; check("cred_rsp_rdy", rsp_ready_in, 1);
        step();
        rsp_valid_in = 1'b0;
        #1;
        check("cred_rsp_valid", rsp_valid_out, 4'b0010);
        check("cred_rsp_tag", rsp_tag_out[1], 8'h33);
        check("cred_rsp_data", rsp_data_out[1], 32'hCAFE_0001);
        check("cred_still_stall", req_ready_in, 0);
        step();
        check("cred_pend_dec", dut.pend[1], 1);
        check("cred_rsp_done", rsp_valid_out, 0);
        check("cred_regrant", req_ready_in, 4'b0010);
        step();
        check("cred_pend_again", dut.pend[1], 2);
        check("cred_req_tag", req_tag_out, {2'd1, 8'h11});

        // backpressure with the requester-1 read held in the register
        req_ready_out = 1'b0;
        req_valid_in  = 4'b1100;
        req_rw_in     = 4'b1100;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_no_grant", req_ready_in, 0);
            check("bp_valid", req_valid_out, 1);
            check("bp_addr", req_addr_out, 26'h111);
            check("bp_rr", dut.rr, 2);
            step();
        end
        req_ready_out = 1'b1;
        #1; check("bp_release_grant", req_ready_in, 4'b0100);
        step();
        check("bp_release_tag", req_tag_out, {2'd2, 8'h12});
        check("bp_release_data", req_data_out, 32'hD000_0002);

        // routing toward a stalled requester 3
        req_valid_in = 4'b1000;
        req_rw_in    = 4'b0000;
        #1; check("rt_grant3", req_ready_in, 4'b1000);
        step();
        req_valid_in  = 4'b0000;
        check("rt_pend3", dut.pend[3], 1);
        rsp_ready_out = 4'b0111;
        rsp_valid_in  = 1'b1;
        rsp_tag_in    = {2'd3, 8'hA5};
        step();
        rsp_valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("rt_valid", rsp_valid_out, 4'b1000);
            check("rt_tag", rsp_tag_out[3], 8'hA5);
            check("rt_ready_in", rsp_ready_in, 0);
            check("rt_pend_hold", dut.pend[3], 1);
            step();
        end
        rsp_ready_out = 4'hF;
        #1; check("rt_ready_in_rel", rsp_ready_in, 1);
        step();
        check("rt_delivered", rsp_valid_out, 0);
        check("rt_pend_dec", dut.pend[3], 0);

        // read accepted and response delivered for requester 0 in the same cycle
        req_valid_in = 4'b0001;
        rsp_valid_in = 1'b1;
        rsp_tag_in   = {2'd0, 8'h5A};
        #1; check("sim_grant0", req_ready_in, 4'b0001);
        step();
        rsp_valid_in = 1'b0;
        #1;
        check("sim_rsp_valid", rsp_valid_out, 4'b0001);
        check("sim_pend_pre", dut.pend[0], 1);
        check("sim_grant0b", req_ready_in, 4'b0001);
        step();
        req_valid_in = 4'b0000;
        check("sim_pend_same", dut.pend[0], 1);
        check("sim_busy", busy, 1);
`ifdef VX_MEM_SCHED_PERF_EN
        check("perf_reads", perf_reads, 6);
`endif

        // reset with reads outstanding
        check("mid_busy_pre", busy, 1);
        reset = 1'b1;
        step();
        check("mid_req_valid", req_valid_out, 0);
        check("mid_rsp_valid", rsp_valid_out, 0);
        check("mid_busy", busy, 0);
        check("mid_rr", dut.rr, 0);
        check("mid_pend", dut.pend, 0);
`ifdef VX_MEM_SCHED_PERF_EN
        check("mid_perf_stall", perf_stall_cycles, 0);
        check("mid_perf_reads", perf_reads, 0);
`endif
        reset        = 1'b0;
        req_valid_in = 4'b0001;
        req_rw_in    = 4'b0001;
        #1;
        check("post_rst_grant", req_ready_in, 4'b0001);
        check("post_rst_rsp_rdy", rsp_ready_in, 1);
        step();
        req_valid_in = 4'b0000;
        check("post_rst_tag", req_tag_out, {2'd0, 8'h10});

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
